// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and FSM encoding for the I2S playback sequencer
package i2s_pkg;

  localparam int I2S_SLOT_BITS_DEFAULT = 32;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_LEFT  = 2'd2,
    ST_RIGHT = 2'd3
  } i2s_state_e;

endpackage

// File: rtl/i2s_clk_edge_detect.sv
// rtl/i2s_clk_edge_detect.sv - bclk falling-edge and LRC slot-boundary detection
module i2s_clk_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic aud_bclk,
  input  logic aud_lrc,
  output logic bclk_fall,
  output logic boundary,
  output logic slot_is_left
);

  logic bclk_q;
  logic lrc_q;

  // lrc_q only advances on bclk falls so a boundary is always aligned to a fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_q <= 1'b0;
      lrc_q  <= 1'b0;
    end else begin
      bclk_q <= aud_bclk;
      if (bclk_fall) begin
        lrc_q <= aud_lrc;
      end
    end
  end

  assign bclk_fall    = bclk_q & ~aud_bclk;
  assign boundary     = bclk_fall & (aud_lrc != lrc_q);
  assign slot_is_left = ~aud_lrc;

endmodule

// File: rtl/i2s_tx_sequencer.sv
// rtl/i2s_tx_sequencer.sv - buffers stereo pairs and serialises them onto the I2S DAC line
module i2s_tx_sequencer
  import i2s_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int BCLK_PER_SLOT = I2S_SLOT_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              aud_bclk,
  input  logic              aud_lrc,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              aud_dacdat,
  output logic              underrun,
  output logic              frame_err
);

  localparam int SR_W = BCLK_PER_SLOT - 1;
  // One bit of headroom above the slot length so an overlong slot is distinguishable
  localparam int CNT_W = $clog2(BCLK_PER_SLOT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_PER_SLOT - 1);

  logic bclk_fall, boundary, slot_is_left;

  i2s_clk_edge_detect u_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .aud_bclk    (aud_bclk),
    .aud_lrc     (aud_lrc),
    .bclk_fall   (bclk_fall),
    .boundary    (boundary),
    .slot_is_left(slot_is_left)
  );

  i2s_state_e        state_q, state_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d, rhold_q, rhold_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              dacdat_q, dacdat_d;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;
  logic              s_ready_q;
  logic              accept, left_bnd, playing, enter_left;

  function automatic logic [SR_W-1:0] align(input logic [DATA_W-1:0] s);
    return SR_W'(s) << (SR_W - DATA_W);
  endfunction

  always_comb begin
    accept      = s_valid & s_ready_q;
    left_bnd    = boundary & slot_is_left;
    playing     = (state_q == ST_LEFT) | (state_q == ST_RIGHT);
    enter_left  = 1'b0;
    state_d     = state_q;
    buf_full_d  = buf_full_q;
    buf_l_d     = buf_l_q;
    buf_r_d     = buf_r_q;
    rhold_d     = rhold_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    dacdat_d    = dacdat_q;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    if (accept) begin
      buf_full_d = 1'b1;
      buf_l_d    = s_left;
      buf_r_d    = s_right;
    end

    if (bclk_fall) begin
      bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
      dacdat_d  = playing & sr_q[SR_W-1];
      sr_d      = sr_q << 1;
    end

    // Boundary fall emits the I2S delay bit and restarts slot counting
    if (boundary) begin
      bit_cnt_d   = '0;
      dacdat_d    = 1'b0;
      frame_err_d = playing && (bit_cnt_q != CNT_LAST);
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!enable) state_d = ST_IDLE;
        else if (left_bnd) enter_left = 1'b1;
      end
      ST_LEFT: begin
        if (boundary && !slot_is_left) begin
          state_d = ST_RIGHT;
          sr_d    = align(rhold_q);
        end
      end
      ST_RIGHT: begin
        if (left_bnd) begin
          if (enable) enter_left = 1'b1;
          else state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pair accepted this very cycle is not yet in buf_full_q, so it waits a frame
    if (enter_left) begin
      state_d = ST_LEFT;
      if (buf_full_q) begin
        sr_d       = align(buf_l_q);
        rhold_d    = buf_r_q;
        buf_full_d = 1'b0;
      end else begin
        sr_d       = '0;
        rhold_d    = '0;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      buf_full_q  <= 1'b0;
      buf_l_q     <= '0;
      buf_r_q     <= '0;
      rhold_q     <= '0;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_full_q  <= buf_full_d;
      buf_l_q     <= buf_l_d;
      buf_r_q     <= buf_r_d;
      rhold_q     <= rhold_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
      s_ready_q   <= ~buf_full_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign aud_dacdat = dacdat_q;
  assign underrun   = underrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// tb/tb_i2s_tx_sequencer.sv - randomized self-checking bench with a slot-level playback model
module tb_i2s_tx_sequencer;

  localparam int DATA_W = 16;
  localparam int SLOT   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic aud_bclk = 1'b1;
  logic aud_lrc = 1'b0;
  logic s_valid = 1'b0;
  logic [DATA_W-1:0] s_left = '0;
  logic [DATA_W-1:0] s_right = '0;
  logic s_ready, aud_dacdat, underrun, frame_err;

  always #5 clk = ~clk;

  i2s_tx_sequencer #(.DATA_W(DATA_W), .BCLK_PER_SLOT(SLOT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .aud_bclk  (aud_bclk),
    .aud_lrc   (aud_lrc),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_left    (s_left),
    .s_right   (s_right),
    .aud_dacdat(aud_dacdat),
    .underrun  (underrun),
    .frame_err (frame_err)
  );

  int total = 0;
  int bad = 0;

  // model: mode 0 idle, 1 waiting for frame start, 2 left slot, 3 right slot
  int m_mode, m_pos;
  int m_lbnd = 0;
  int m_frames = 0;
  bit m_prev_bclk, m_lrc_q, m_full, m_ready, m_dac, m_ur, m_fe, m_fall;
  logic [DATA_W-1:0] m_bl, m_br, m_cur, m_rh;
  bit chk_en = 0;

  int g_ph = 0;
  int g_pos = 0;
  int g_len = SLOT;
  bit stretch_req = 0;
  bit g_lbnd = 0;

  logic [63:0] cap = '0;
  int ur_cnt = 0;
  int fe_cnt = 0;
  int ones_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready", s_ready, m_ready);
      check("dacdat", aud_dacdat, m_dac);
      check("underrun", underrun, m_ur);
      check("frame_err", frame_err, m_fe);
    end
    if (m_fall) cap = {cap[62:0], aud_dacdat};
    ur_cnt   += int'(underrun);
    fe_cnt   += int'(frame_err);
    ones_cnt += int'(aud_dacdat);
  end

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_prev_bclk = 0; m_lrc_q = 0; m_full = 0; m_ready = 0;
    m_dac = 0; m_ur = 0; m_fe = 0; m_fall = 0;
    m_bl = '0; m_br = '0; m_cur = '0; m_rh = '0;
  endtask

  // Evaluates what the outputs must be after the clock edge that just sampled the inputs
  task automatic model_step();
    bit acc, bnd, play;
    int old;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = s_valid && m_ready;
    old = m_mode;
    play = (old >= 2);
    m_fall = m_prev_bclk && !aud_bclk;
    m_prev_bclk = aud_bclk;
    m_ur = 0;
    m_fe = 0;
    if (m_fall) begin
      bnd = (aud_lrc != m_lrc_q);
      m_lrc_q = aud_lrc;
      if (bnd) begin
        m_fe = play && (m_pos != SLOT - 1);
        m_pos = 0;
        m_dac = 0;
        if (!aud_lrc) begin
          m_lbnd++;
          if ((old == 1 || old == 3) && enable) begin
            m_mode = 2;
            m_frames++;
            if (m_full) begin
              m_cur = m_bl; m_rh = m_br; m_full = 0;
            end else begin
              m_cur = '0; m_rh = '0; m_ur = 1;
            end
          end else if (old == 3) begin
            m_mode = 0;
          end
        end else if (old == 2) begin
          m_mode = 3;
          m_cur = m_rh;
        end
      end else begin
        m_pos++;
        m_dac = (play && m_pos >= 1 && m_pos <= DATA_W) ? m_cur[DATA_W-m_pos] : 1'b0;
      end
    end
    if (old == 0 && enable) m_mode = 1;
    else if (old == 1 && !enable) m_mode = 0;
    if (acc) begin
      m_full = 1; m_bl = s_left; m_br = s_right;
    end
    m_ready = !m_full;
  endtask

  // 4 clk per bclk; LRC toggles on the fall that starts a slot
  task automatic gen_step();
    g_lbnd = 0;
    g_ph = (g_ph + 1) % 4;
    if (g_ph == 0) begin
      aud_bclk = 1'b1;
    end else if (g_ph == 2) begin
      aud_bclk = 1'b0;
      g_pos++;
      if (g_pos >= g_len) begin
        g_pos = 0;
        aud_lrc = ~aud_lrc;
        g_len = stretch_req ? SLOT + 1 : SLOT;
        stretch_req = 0;
        g_lbnd = !aud_lrc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    gen_step();
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout %s: got no event expected event", name);
  endtask

  task automatic wait_lbnd(input int n);
    int target = m_lbnd + n;
    int budget = n * 600 + 600;
    while (m_lbnd < target && budget > 0) begin tick(); budget--; end
    if (m_lbnd < target) timeout("left_boundary");
  endtask

  task automatic wait_frames(input int n);
    int target = m_frames + n;
    int budget = n * 600 + 900;
    while (m_frames < target && budget > 0) begin tick(); budget--; end
    if (m_frames < target) timeout("frame_start");
  endtask

  task automatic wait_mode(input int md);
    int budget = 900;
    while (m_mode != md && budget > 0) begin tick(); budget--; end
    if (m_mode != md) timeout("mode");
  endtask

  task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    s_valid = 1'b1; s_left = l; s_right = r;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    int budget;
    model_reset();
    tick();
    chk_en = 1;
    tick();
    tick();
    at_neg();
    check("reset_ready", s_ready, 0);
    check("reset_dac", aud_dacdat, 0);
    check("reset_ur", underrun, 0);
    check("reset_fe", frame_err, 0);
    rst_n = 1'b1;
    tick();
    tick();
    at_neg();
    check("ready_after_reset", s_ready, 1);

    push_pair(16'hA5F0, 16'h0F0F);
    tick();
    at_neg();
    check("ready_when_full", s_ready, 0);
    enable = 1'b1;
    wait_frames(1);
    wait_lbnd(1);
    at_neg();
    check("first_frame_bits", cap, 64'hA5F0_0000_0F0F_0000);
    check("ready_after_consume", s_ready, 1);

    ur_cnt = 0;
    ones_cnt = 0;
    wait_lbnd(3);
    at_neg();
    check("underrun_per_frame", ur_cnt, 3);
    check("silent_underrun", ones_cnt, 0);

    ur_cnt = 0;
    budget = 600;
    while (!g_lbnd && budget > 0) begin tick(); budget--; end
    if (!g_lbnd) timeout("boundary_align");
    push_pair(16'h8001, 16'h7FFE);
    at_neg();
    check("same_cycle_underrun", ur_cnt, 1);
    wait_lbnd(2);
    at_neg();
    check("late_pair_bits", cap, 64'h8001_0000_7FFE_0000);

    fe_cnt = 0;
    push_pair(16'h1234, 16'hFEDC);
    stretch_req = 1;
    wait_lbnd(3);
    at_neg();
    check("stretch_frame_err", fe_cnt, 1);

    wait_mode(2);
    push_pair(16'hBEEF, 16'h1357);
    wait_mode(3);
    repeat (40) tick();
    enable = 1'b0;
    wait_lbnd(1);
    at_neg();
    ones_cnt = 0;
    wait_lbnd(2);
    at_neg();
    check("idle_silent", ones_cnt, 0);
    check("idle_keeps_pair", s_ready, 0);

    enable = 1'b1;
    wait_frames(1);
    repeat (30) tick();
    rst_n = 1'b0;
    model_reset();
    at_neg();
    check("midrst_dac", aud_dacdat, 0);
    check("midrst_ready", s_ready, 0);
    check("midrst_ur", underrun, 0);
    check("midrst_fe", frame_err, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    ur_cnt = 0;
    wait_frames(1);
    at_neg();
    check("reset_discards_pair", ur_cnt, 1);

    repeat (6000) begin
      tick();
      if ($urandom_range(0, 39) == 0) begin
        s_valid = 1'b1;
        s_left  = DATA_W'($urandom);
        s_right = DATA_W'($urandom);
      end else begin
        s_valid = 1'b0;
      end
      if ($urandom_range(0, 1499) == 0) enable = ~enable;
      if ($urandom_range(0, 2999) == 0) stretch_req = 1;
    end
    s_valid = 1'b0;
    at_neg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
